pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one field.
REQ-002 The block SHALL have parameter NUM_FIELDS, default 3, meaning the field count per entry (PC, instruction, jump target).
REQ-003 The block SHALL have parameter SKID, default 1: 1 gives a two-entry skid buffer, 0 gives a single entry.
REQ-004 The block SHALL have parameter RESET_VAL, default 0, meaning the per-field value loaded on reset, flush or bubble.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage accepts the entry this cycle.
REQ-009 The block SHALL have port in_data, input, NUM_FIELDS*DATA_W bits: upstream fields, with field 0 in the LSBs.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous kill of all held entries.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the entry.
REQ-013 The block SHALL have port out_data, output, NUM_FIELDS*DATA_W bits: the head entry fields.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of valid entries held (0..2).

Function
REQ-015 A transfer SHALL occur on in_valid&&in_ready (accept) and on out_valid&&out_ready (retire), each evaluated at the rising clk edge.
REQ-016 With SKID=1, the block SHALL hold a main entry (drives out_*) and a skid entry; in_ready SHALL equal !skid_valid && !flush, with no combinational path from out_ready.
REQ-017 With SKID=0, the block SHALL hold the main entry only; in_ready SHALL equal (!main_valid || out_ready) && !flush.
REQ-018 In the main-empty case, an accept SHALL load main; out_valid SHALL rise one cycle later (latency 1).
REQ-019 When main is full with a retire and accept in the same cycle, the incoming entry SHALL replace main; out_valid SHALL stay 1 with no bubble.
REQ-020 When main is full with no retire and an accept (SKID=1), the incoming entry SHALL load skid; in_ready SHALL drop on the next cycle.
REQ-021 When skid is full and a retire occurs, skid SHALL move to main, skid SHALL clear, and in_ready SHALL rise on the next cycle.
REQ-022 Entry order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except by flush.
REQ-023 An invalid entry SHALL hold RESET_VAL in every field, so out_data equals RESET_VAL whenever out_valid=0 (NOP bubble).
REQ-024 Flush SHALL clear main and skid valid and data to RESET_VAL at the next edge, overriding any same-cycle accept or retire.
REQ-025 Data SHALL NOT change on a stall: while out_valid&&!out_ready, out_data SHALL be held stable.
REQ-026 occupancy SHALL equal main_valid+skid_valid, registered, and SHALL never exceed 1 when SKID=0.

Reset
REQ-027 Asserting rst low SHALL asynchronously clear main_valid and skid_valid, set all data fields to RESET_VAL, and give occupancy=0 and out_valid=0.
REQ-028 While rst is low, in_ready SHALL be 0; in_ready SHALL become 1 on the first clk edge after deassertion, with no accept during reset.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries with no partial state retained.

Structure
REQ-030 Package pipe_pkg SHALL hold the default DATA_W, RESET_VAL and the field index constants F_PC=0, F_INSTR=1, F_JUMP=2.
REQ-031 One sub-module, pipe_entry, SHALL be used: a valid+data register with load/clear, instantiated once for main and, when SKID=1, once for skid.
REQ-032 The RTL SHALL use no latches, no multiple clocks, and only generate-based SKID selection.

Verification
REQ-033 The bench SHALL cover: reset, then in_data={F_JUMP=0x40,F_INSTR=0x8C220004,F_PC=0x4}, in_valid=1, out_ready=1 -> out_valid=1 next cycle with matching out_data, occupancy=1.
REQ-034 The bench SHALL cover: SKID=1, out_ready=0, two accepts 0x10 then 0x14 -> occupancy=2, in_ready=0, out_data shows 0x10; set out_ready=1 -> 0x10 then 0x14 retire in order.
REQ-035 The bench SHALL cover: flush with in_valid=1 and occupancy=2 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL, and the input not accepted.
REQ-036 The bench SHALL cover: a continuous stream 0x0,0x4,...,0x3C with out_ready=1 -> 16 outputs on 16 consecutive cycles, no bubbles.
REQ-037 The bench SHALL cover: SKID=0, out_ready toggling 1,0,1 -> in_ready follows out_ready when main is full; no loss or duplication.
REQ-038 The bench SHALL cover: rst pulsed low mid-cycle while occupancy=2 -> immediate out_valid=0 and occupancy=0 without waiting for clk.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and field layout for the fetch/decode pipeline register.
// Field 0 sits in the LSBs of every entry word.
package pipe_pkg;
   localparam int          DEF_DATA_W    = 32;
   localparam int          DEF_FIELDS    = 3;
   localparam logic [31:0] DEF_RESET_VAL = 32'h0;

   localparam int F_PC    = 0;
   localparam int F_INSTR = 1;
   localparam int F_JUMP  = 2;
endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: a valid bit plus its data word.
// A cleared or invalid entry always holds the reset word.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int           W        = 96,
   parameter logic [W-1:0] RST_WORD = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Clear wins so a flush beats any same-cycle load.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         data_d  = RST_WORD;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= RST_WORD;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid entry.
// With a skid entry in_ready is fully registered against out_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                NUM_FIELDS = DEF_FIELDS,
   parameter int                SKID       = 1,
   parameter logic [DATA_W-1:0] RESET_VAL  = DATA_W'(DEF_RESET_VAL)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_FIELDS*DATA_W-1:0] out_data,
   output logic [1:0]                   occupancy
);

   localparam int           W        = NUM_FIELDS * DATA_W;
   localparam logic [W-1:0] RST_WORD = {NUM_FIELDS{RESET_VAL}};

   logic         main_valid, skid_valid;
   logic [W-1:0] main_data, skid_data;
   logic         main_load, main_clear;
   logic [W-1:0] main_d;
   logic         skid_load, skid_clear;
   logic         main_nv, skid_nv;
   logic         accept, retire;
   logic         rdy_q, rdy_d;
   logic [1:0]   occ_q, occ_d;

   always_comb begin
      accept     = in_valid && in_ready;
      retire     = main_valid && out_ready;
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_d     = in_data;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_nv    = main_valid;
      skid_nv    = skid_valid;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
         main_nv    = 1'b0;
         skid_nv    = 1'b0;
      end else if (!main_valid) begin
         if (accept) begin
            main_load = 1'b1;
            main_nv   = 1'b1;
         end
      end else if (retire) begin
         if (skid_valid) begin
            main_load  = 1'b1;
            main_d     = skid_data;
            skid_clear = 1'b1;
            skid_nv    = 1'b0;
         end else if (accept) begin
            main_load = 1'b1;
         end else begin
            main_clear = 1'b1;
            main_nv    = 1'b0;
         end
      end else if (accept) begin
         skid_load = 1'b1;
         skid_nv   = 1'b1;
      end
      occ_d = {1'b0, main_nv} + {1'b0, skid_nv};
      rdy_d = 1'b1;
   end

   // Holds in_ready low through reset until the first clean edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_q <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         rdy_q <= rdy_d;
         occ_q <= occ_d;
      end
   end

   pipe_entry #(
      .W        (W),
      .RST_WORD (RST_WORD)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .data  (main_data)
   );

   if (SKID != 0) begin : g_skid
      pipe_entry #(
         .W        (W),
         .RST_WORD (RST_WORD)
      ) u_skid (
         .clk   (clk),
         .rst   (rst),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (in_data),
         .valid (skid_valid),
         .data  (skid_data)
      );
      assign in_ready = rdy_q && !skid_valid && !flush;
   end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = RST_WORD;
      assign in_ready   = rdy_q && (!main_valid || out_ready) && !flush;
   end

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and no-skid instances.
// Inputs change and outputs are sampled on the falling edge.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int W = 96;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, flush, out_valid, out_ready;
   logic [W-1:0] in_data, out_data;
   logic [1:0]   occupancy;

   logic         in_valid0, in_ready0, flush0, out_valid0, out_ready0;
   logic [W-1:0] in_data0, out_data0;
   logic [1:0]   occupancy0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.SKID(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   pipe_stage_reg #(.SKID(0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .in_data   (in_data0),
      .flush     (flush0),
      .out_valid (out_valid0),
      .out_ready (out_ready0),
      .out_data  (out_data0),
      .occupancy (occupancy0)
   );

   function automatic logic [W-1:0] mk(input logic [31:0] pc,
                                       input logic [31:0] ins,
                                       input logic [31:0] jmp);
      return {jmp, ins, pc};
   endfunction

   task automatic fill_two();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = mk(32'h10, 0, 0);
      @(negedge clk);
      in_data   = mk(32'h14, 0, 0);
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_out_valid got %b want 0", out_valid);
      end
      n_cmp++;
      if (occupancy !== 2'd0) begin
         n_bad++;
         $display("FAIL rst_occ got %0d want 0", occupancy);
      end
      n_cmp++;
      if (out_data !== '0) begin
         n_bad++;
         $display("FAIL rst_out_data got %h want 0", out_data);
      end
      n_cmp++;
      if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_in_ready got %b/%b want 0/0",
                  in_ready, in_ready0);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_rel_ready_early got %b want 0", in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_rel_ready got %b/%b want 1/1",
                  in_ready, in_ready0);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] exp;
      exp       = mk(32'h4, 32'h8C220004, 32'h40);
      in_valid  = 1'b1;
      in_data   = exp;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
         n_bad++;
         $display("FAIL single_out got v=%b d=%h want v=1 d=%h",
                  out_valid, out_data, exp);
      end
      n_cmp++;
      if (occupancy !== 2'd1) begin
         n_bad++;
         $display("FAIL single_occ got %0d want 1", occupancy);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin
         n_bad++;
         $display("FAIL single_drain got v=%b d=%h o=%0d want 0/0/0",
                  out_valid, out_data, occupancy);
      end
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = mk(32'h10, 0, 0);
      @(negedge clk);
      in_data = mk(32'h14, 0, 0);
      n_cmp++;
      if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
         n_bad++;
         $display("FAIL skid_one got rdy=%b o=%0d want 1/1",
                  in_ready, occupancy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL skid_full got o=%0d rdy=%b want 2/0",
                  occupancy, in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== mk(32'h10, 0, 0)) begin
         n_bad++;
         $display("FAIL skid_head got v=%b d=%h want 1/10",
                  out_valid, out_data);
      end
      @(negedge clk);
      n_cmp++;
      if (out_data !== mk(32'h10, 0, 0) || occupancy !== 2'd2) begin
         n_bad++;
         $display("FAIL skid_stall got d=%h o=%0d want 10/2",
                  out_data, occupancy);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== mk(32'h14, 0, 0)) begin
         n_bad++;
         $display("FAIL skid_second got v=%b d=%h want 1/14",
                  out_valid, out_data);
      end
      n_cmp++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL skid_reopen got o=%0d rdy=%b want 1/1",
                  occupancy, in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_bad++;
         $display("FAIL skid_empty got v=%b o=%0d want 0/0",
                  out_valid, occupancy);
      end
   endtask

   task automatic test_flush();
      fill_two();
      in_valid = 1'b1;
      in_data  = mk(32'h99, 0, 0);
      flush    = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin
         n_bad++;
         $display("FAIL flush_clear got o=%0d v=%b d=%h want 0/0/0",
                  occupancy, out_valid, out_data);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_bad++;
         $display("FAIL flush_noaccept got v=%b o=%0d want 0/0",
                  out_valid, occupancy);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            n_cmp++;
            if (out_valid !== 1'b1 ||
                out_data !== mk(32'(4 * (i - 1)), 0, 0)) begin
               n_bad++;
               $display("FAIL stream_%0d got v=%b d=%h want 1/%h",
                        i - 1, out_valid, out_data, 4 * (i - 1));
            end
         end
         if (i < 16) begin
            in_valid = 1'b1;
            in_data  = mk(32'(4 * i), 0, 0);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_bad++;
         $display("FAIL stream_end got v=%b o=%0d want 0/0",
                  out_valid, occupancy);
      end
   endtask

   task automatic test_noskid();
      in_valid0  = 1'b1;
      in_data0   = mk(32'h100, 0, 0);
      out_ready0 = 1'b1;
      @(negedge clk);
      in_data0   = mk(32'h104, 0, 0);
      out_ready0 = 1'b0;
      #1;
      n_cmp++;
      if (in_ready0 !== 1'b0 || out_data0 !== mk(32'h100, 0, 0)) begin
         n_bad++;
         $display("FAIL ns_stall got rdy=%b d=%h want 0/100",
                  in_ready0, out_data0);
      end
      @(negedge clk);
      n_cmp++;
      if (out_data0 !== mk(32'h100, 0, 0) || occupancy0 !== 2'd1) begin
         n_bad++;
         $display("FAIL ns_hold got d=%h o=%0d want 100/1",
                  out_data0, occupancy0);
      end
      out_ready0 = 1'b1;
      #1;
      n_cmp++;
      if (in_ready0 !== 1'b1) begin
         n_bad++;
         $display("FAIL ns_ready got %b want 1", in_ready0);
      end
      @(negedge clk);
      in_valid0 = 1'b0;
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_data0 !== mk(32'h104, 0, 0) ||
          occupancy0 !== 2'd1) begin
         n_bad++;
         $display("FAIL ns_second got v=%b d=%h o=%0d want 1/104/1",
                  out_valid0, out_data0, occupancy0);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0) begin
         n_bad++;
         $display("FAIL ns_empty got v=%b o=%0d want 0/0",
                  out_valid0, occupancy0);
      end
   endtask

   task automatic test_async_reset();
      fill_two();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
         n_bad++;
         $display("FAIL arst_clear got v=%b o=%0d d=%h want 0/0/0",
                  out_valid, occupancy, out_data);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_after got rdy=%b o=%0d v=%b want 1/0/0",
                  in_ready, occupancy, out_valid);
      end
   endtask

   initial begin
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      in_valid0  = 1'b0;
      in_data0   = '0;
      flush0     = 1'b0;
      out_ready0 = 1'b0;
      test_reset();
      test_single();
      test_skid();
      test_flush();
      test_back_to_back();
      test_noskid();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
